uart_frame_responder: RTL and testbench
=======================================

# uart_frame_responder

Framed command responder that sits between the UART receiver and transmitter tops on the far end of the serial link. It drains received bytes from the RX FIFO read port and parses frames of the form SOF, LEN, payload, CHK. Valid frames are echoed back through the TX FIFO write port as a response frame. Malformed or stalled frames are answered with a NAK frame or discarded, and are flagged on status pulses.

## Interface

- `MAX_LEN`, default 16: maximum payload length in bytes, valid range 1..255; sets payload buffer depth.
- `TIMEOUT_CYC`, default 21700: mid-frame idle limit in clk cycles (10 character times at 115200 baud, 25 MHz).
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `r_data`, in, 8: RX FIFO head byte; first-word-fall-through, valid while `rx_fifo_empty`=0.
- `rx_fifo_empty`, in, 1: RX FIFO empty flag.
- `rd_uart`, out, 1: one-cycle pop of the RX FIFO; consumes `r_data` in the same cycle.
- `tx_fifo_full`, in, 1: TX FIFO full flag.
- `wr_uart`, out, 1: one-cycle push of `w_data` into the TX FIFO.
- `w_data`, out, 8: response byte.
- `frame_ok`, out, 1: one-cycle pulse when a valid frame's response has been fully written.
- `frame_err`, out, 1: one-cycle pulse on a checksum error, bad LEN, or timeout.
- `busy`, out, 1: high in every state except HUNT.

## Operation

- Frame format:
  - Request: 0xA5, LEN, LEN payload bytes, CHK.
  - CHK = XOR of LEN and all payload bytes.
  - Valid LEN range is 1..MAX_LEN.
- Responses:
  - ACK response: 0x5A, LEN, payload echoed in order, CHK recomputed as the XOR of LEN and the payload.
  - NAK response: 0x5A, 0x00, 0x00.
- States and transitions:
  - HUNT: pop bytes as available. 0xA5 goes to LEN. Any other byte is discarded silently.
  - LEN: pop one byte. If LEN is 0 or greater than MAX_LEN, go to NAK_HDR with a `frame_err` pulse. Otherwise latch LEN, set the running XOR to LEN, clear the index, and go to PAYLOAD.
  - PAYLOAD: each pop stores the byte at buf[idx], XORs it into the running XOR, and increments idx. After the LEN-th byte, go to CHK.
  - CHK: pop one byte and go to CHECK.
  - CHECK (one cycle, no FIFO access): if the popped CHK equals the running XOR, go to RESP_HDR. Otherwise pulse `frame_err` and go to NAK_HDR.
  - RESP_HDR, RESP_LEN, RESP_PAY, RESP_CHK: write 0x5A, LEN, buf[0..LEN-1], and the running XOR, in that order. `frame_ok` pulses in the cycle of the final write, then return to HUNT.
  - NAK_HDR, NAK_LEN, NAK_CHK: write 0x5A, 0x00, 0x00, then return to HUNT.
- RX read rules:
  - `rd_uart` is asserted only in HUNT, LEN, PAYLOAD and CHK, and only when `rx_fifo_empty`=0.
  - After any pop, `rd_uart` must be 0 in the next cycle, giving at most one pop per 2 cycles. This absorbs the FIFO flag update lag.
  - `rd_uart` is never asserted in CHECK or any response state; bytes arriving then wait in the RX FIFO.
- TX write rules:
  - `wr_uart` is asserted only when `tx_fifo_full`=0, with at most one write per 2 cycles.
  - `w_data` is stable during the push cycle.
  - While full, the current byte is held and the state does not advance.
- Timeout:
  - In LEN, PAYLOAD and CHK, a counter increments each cycle without a pop and clears on every pop.
  - When it reaches TIMEOUT_CYC: pulse `frame_err`, go to HUNT, no response.
  - The counter is idle in HUNT.
- The payload buffer is MAX_LEN x 8 registers or RAM. Its contents are don't-care after reset.

## Timing

- Reset values:
  - `rd_uart`=0, `wr_uart`=0, `w_data`=0x00, `frame_ok`=0, `frame_err`=0, `busy`=0.
  - State = HUNT, counters = 0, running XOR = 0.
- Reset asserted mid-frame or mid-response aborts immediately (asynchronous). No partial response resumes after release.
- CHK popped in cycle N: CHECK is in N+1, and the first `wr_uart` occurs no earlier than N+2, provided `tx_fifo_full`=0.
- Unstalled response of LEN bytes: LEN+3 writes spanning 2·(LEN+3)−1 cycles.
- `frame_err` for bad LEN is asserted in the cycle after the LEN pop.
- `frame_err` for a bad checksum is asserted in the CHECK cycle.
- `frame_err` for a timeout is asserted in the cycle the counter hits TIMEOUT_CYC.
- The idx and LEN counters are 8-bit. The comparison idx == LEN−1 terminates PAYLOAD, so no wrap is possible for LEN ≤ 255.

## Test plan

- Valid frame: RX FIFO loaded with A5 03 11 22 33 03 -> TX receives 5A 03 11 22 33 03, one `frame_ok` pulse, no `frame_err`, `busy` low afterwards.
- Bad checksum: A5 02 AA 55 00 (the correct CHK is FD) -> TX receives 5A 00 00, one `frame_err` pulse, and the next valid frame is echoed correctly.
- Leading garbage: 00 FF A5 01 7E 7F -> 00 and FF are popped and discarded, TX receives 5A 01 7E 7F, no `frame_err`.
- Bad LEN: A5 00 -> NAK 5A 00 00. Then A5 11 (with MAX_LEN=16) -> NAK, and the following bytes are hunted as non-SOF.
- Timeout: A5 04 01, then RX FIFO empty for TIMEOUT_CYC cycles -> `frame_err` pulse, no TX writes, HUNT; a following A5 01 42 43 yields 5A 01 42 43.
- Backpressure and reset:
  - Hold `tx_fifo_full`=1 during a response -> `wr_uart` stays 0; after release the bytes complete in order, and no pops occur during the stall.
  - Assert `reset` mid-response -> all outputs go to reset values without a clock edge; after release, no residual writes.

Source files
------------

// File: rtl/uart_frame_responder.sv
// uart_frame_responder: parses SOF/LEN/payload/CHK frames from the RX FIFO
// and answers through the TX FIFO with an echo (ACK) frame or a NAK frame.
// Each FIFO port is accessed at most once every two cycles. This gives the
// FIFO flags time to update after a pop or push.
module uart_frame_responder #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 21700
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r_data,
  input  logic       rx_fifo_empty,
  output logic       rd_uart,
  input  logic       tx_fifo_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int              IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              CW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0]   TMO       = CW'(TIMEOUT_CYC);
  localparam logic [7:0]      SOF       = 8'hA5;
  localparam logic [7:0]      RSP       = 8'h5A;

  typedef enum logic [3:0] {
    HUNT, LEN, PAYLOAD, CHK, CHECK,
    RESP_HDR, RESP_LEN, RESP_PAY, RESP_CHK,
    NAK_HDR, NAK_LEN, NAK_CHK
  } state_t;

  state_t          state, state_n;
  logic            gap;        // a FIFO access happened last cycle
  logic [CW-1:0]   tmo_cnt;
  logic [7:0]      len_q;
  logic [7:0]      idx;
  logic [7:0]      xor_q;
  logic [7:0]      chk_q;
  logic            err_len_q;
  logic [7:0]      pay_mem [MAX_LEN];

  logic            in_rx;
  logic            timeout;
  logic            rx_ok;
  logic            tx_ok;
  logic            len_bad;
  logic            last_idx;
  logic            chk_bad;
  logic [IW-1:0]   pidx;

  assign pidx     = idx[IW-1:0];
  assign in_rx    = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  assign timeout  = in_rx && (tmo_cnt == TMO);
  assign rx_ok    = !rx_fifo_empty && !gap;
  assign tx_ok    = !tx_fifo_full && !gap;
  assign len_bad  = (r_data == 8'h00) || (r_data > MAX_LEN_B);
  assign last_idx = (idx == (len_q - 8'd1));
  assign chk_bad  = (chk_q != xor_q);

  // Next-state decode plus FIFO strobes, response byte and status pulses.
  always_comb begin
    state_n   = state;
    rd_uart   = 1'b0;
    wr_uart   = 1'b0;
    w_data    = 8'h00;
    frame_ok  = 1'b0;
    frame_err = err_len_q || timeout || ((state == CHECK) && chk_bad);
    busy      = (state != HUNT);
    case (state)
      HUNT: begin
        if (rx_ok) begin
          rd_uart = 1'b1;
          if (r_data == SOF) state_n = LEN;
        end
      end
      LEN: begin
        if (timeout) begin
          state_n = HUNT;
        end else if (rx_ok) begin
          rd_uart = 1'b1;
          state_n = len_bad ? NAK_HDR : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (timeout) begin
          state_n = HUNT;
        end else if (rx_ok) begin
          rd_uart = 1'b1;
          if (last_idx) state_n = CHK;
        end
      end
      CHK: begin
        if (timeout) begin
          state_n = HUNT;
        end else if (rx_ok) begin
          rd_uart = 1'b1;
          state_n = CHECK;
        end
      end
      CHECK: state_n = chk_bad ? NAK_HDR : RESP_HDR;
      RESP_HDR: begin
        w_data = RSP;
        if (tx_ok) begin
          wr_uart = 1'b1;
          state_n = RESP_LEN;
        end
      end
      RESP_LEN: begin
        w_data = len_q;
        if (tx_ok) begin
          wr_uart = 1'b1;
          state_n = RESP_PAY;
        end
      end
      RESP_PAY: begin
        w_data = pay_mem[pidx];
        if (tx_ok) begin
          wr_uart = 1'b1;
          if (last_idx) state_n = RESP_CHK;
        end
      end
      RESP_CHK: begin
        w_data = xor_q;
        if (tx_ok) begin
          wr_uart  = 1'b1;
          frame_ok = 1'b1;
          state_n  = HUNT;
        end
      end
      NAK_HDR: begin
        w_data = RSP;
        if (tx_ok) begin
          wr_uart = 1'b1;
          state_n = NAK_LEN;
        end
      end
      NAK_LEN: begin
        if (tx_ok) begin
          wr_uart = 1'b1;
          state_n = NAK_CHK;
        end
      end
      NAK_CHK: begin
        if (tx_ok) begin
          wr_uart = 1'b1;
          state_n = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // State register; reset releases into HUNT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_n;
  end

  // Frame bookkeeping: access spacing, idle timeout, LEN/index/XOR tracking.
  // gap resets high so no pop can fire while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap       <= 1'b1;
      tmo_cnt   <= '0;
      len_q     <= 8'h00;
      idx       <= 8'h00;
      xor_q     <= 8'h00;
      chk_q     <= 8'h00;
      err_len_q <= 1'b0;
    end else begin
      gap       <= rd_uart || wr_uart;
      err_len_q <= (state == LEN) && rd_uart && len_bad;
      if (!in_rx || rd_uart || timeout) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + CW'(1);
      if (state == LEN && rd_uart && !len_bad) begin
        len_q <= r_data;
        xor_q <= r_data;
        idx   <= 8'h00;
      end
      if (state == PAYLOAD && rd_uart) begin
        xor_q <= xor_q ^ r_data;
        idx   <= idx + 8'd1;
      end
      if (state == CHK && rd_uart) chk_q <= r_data;
      if (state == RESP_LEN && wr_uart) idx <= 8'h00;
      if (state == RESP_PAY && wr_uart) idx <= idx + 8'd1;
    end
  end

  // Payload buffer; contents are only meaningful within the current frame.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rd_uart) pay_mem[pidx] <= r_data;
  end

endmodule

// File: tb/tb_uart_frame_responder.sv
// Directed bench for uart_frame_responder with behavioural RX/TX FIFO models.
module tb_uart_frame_responder;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] r_data = 8'h00;
  logic       rx_fifo_empty = 1'b1;
  logic       rd_uart;
  logic       tx_fifo_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  uart_frame_responder #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .r_data(r_data), .rx_fifo_empty(rx_fifo_empty),
    .rd_uart(rd_uart), .tx_fifo_full(tx_fifo_full), .wr_uart(wr_uart),
    .w_data(w_data), .frame_ok(frame_ok), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  logic [7:0] stim[$];
  int         wcq[$];
  int         pcq[$];
  int         rx_rd = 0;
  int         cyc = 0, oks = 0, errs = 0, tx_viol = 0, rd_viol = 0;
  logic       prev_rd = 1'b0, prev_wr = 1'b0;
  int         tx_base = 0;
  int         n_checks = 0, n_fail = 0;

  // FIFO models: pop/push on the clock edge, flags refreshed on the falling edge
  always @(posedge clk) begin
    cyc++;
    if (rd_uart) begin
      if (rx_fifo_empty || prev_rd) rd_viol++;
      pcq.push_back(cyc);
      rx_rd++;
    end
    if (wr_uart) begin
      if (tx_fifo_full || prev_wr) tx_viol++;
      txq.push_back(w_data);
      wcq.push_back(cyc);
    end
    if (frame_ok)  oks++;
    if (frame_err) errs++;
    prev_rd = rd_uart;
    prev_wr = wr_uart;
  end

  always @(negedge clk) begin
    rx_fifo_empty = (rx_rd >= rxq.size());
    r_data        = rx_fifo_empty ? 8'h00 : rxq[rx_rd];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load();
    foreach (stim[i]) rxq.push_back(stim[i]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((rx_rd < rxq.size() || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_tx(input string tag);
    check_val({tag, "_cnt"}, 32'(txq.size() - tx_base), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (tx_base + i < txq.size())
        check_val($sformatf("%s_b%0d", tag, i), 32'(txq[tx_base + i]), 32'(expq[i]));
    tx_base = txq.size();
  endtask

  int ok0, err0, pop0, n;

  initial begin
    reset        = 1'b0;
    tx_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rd",   32'(rd_uart),   32'd0);
    check_val("rst_wr",   32'(wr_uart),   32'd0);
    check_val("rst_wdat", 32'(w_data),    32'd0);
    check_val("rst_ok",   32'(frame_ok),  32'd0);
    check_val("rst_err",  32'(frame_err), 32'd0);
    check_val("rst_busy", 32'(busy),      32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // valid frame, with latency and span of the response
    ok0 = oks; err0 = errs;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    load();
    wait_idle("valid", 400);
    if (txq.size() >= tx_base + 6) begin
      check_val("valid_chk2wr", 32'(wcq[tx_base] - pcq[pcq.size() - 1]), 32'd2);
      check_val("valid_span",   32'(wcq[tx_base + 5] - wcq[tx_base]), 32'd10);
    end
    expq = '{8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    compare_tx("valid");
    check_val("valid_ok",   32'(oks - ok0),  32'd1);
    check_val("valid_err",  32'(errs - err0), 32'd0);
    check_val("valid_busy", 32'(busy), 32'd0);

    // bad checksum, then a good frame
    ok0 = oks; err0 = errs;
    stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    load();
    wait_idle("badchk", 600);
    expq = '{8'h5A, 8'h00, 8'h00, 8'h5A, 8'h01, 8'h7E, 8'h7F};
    compare_tx("badchk");
    check_val("badchk_err", 32'(errs - err0), 32'd1);
    check_val("badchk_ok",  32'(oks - ok0),   32'd1);

    // leading garbage
    ok0 = oks; err0 = errs; pop0 = pcq.size();
    stim = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    load();
    wait_idle("garb", 400);
    expq = '{8'h5A, 8'h01, 8'h7E, 8'h7F};
    compare_tx("garb");
    check_val("garb_err",  32'(errs - err0), 32'd0);
    check_val("garb_pops", 32'(pcq.size() - pop0), 32'd6);

    // LEN of zero
    err0 = errs;
    stim = '{8'hA5, 8'h00};
    load();
    wait_idle("len0", 200);
    expq = '{8'h5A, 8'h00, 8'h00};
    compare_tx("len0");
    check_val("len0_err", 32'(errs - err0), 32'd1);

    // LEN above MAX_LEN; trailing bytes are hunted and dropped
    err0 = errs; pop0 = pcq.size(); ok0 = oks;
    stim = '{8'hA5, 8'h11, 8'h22, 8'h33};
    load();
    wait_idle("lenbig", 200);
    expq = '{8'h5A, 8'h00, 8'h00};
    compare_tx("lenbig");
    check_val("lenbig_err",  32'(errs - err0), 32'd1);
    check_val("lenbig_pops", 32'(pcq.size() - pop0), 32'd4);
    check_val("lenbig_ok",   32'(oks - ok0), 32'd0);

    // mid-frame timeout, then recovery
    err0 = errs; ok0 = oks;
    stim = '{8'hA5, 8'h04, 8'h01};
    load();
    wait_idle("tmo", 400);
    expq.delete();
    compare_tx("tmo");
    check_val("tmo_err", 32'(errs - err0), 32'd1);
    stim = '{8'hA5, 8'h01, 8'h42, 8'h43};
    load();
    wait_idle("tmo2", 400);
    expq = '{8'h5A, 8'h01, 8'h42, 8'h43};
    compare_tx("tmo2");
    check_val("tmo2_ok", 32'(oks - ok0), 32'd1);

    // TX backpressure: response held, no pops while stalled
    ok0 = oks; pop0 = pcq.size();
    tx_fifo_full = 1'b1;
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32, 8'h00};
    load();
    repeat (60) @(negedge clk);
    check_val("bp_nowr", 32'(txq.size() - tx_base), 32'd0);
    check_val("bp_pops", 32'(pcq.size() - pop0), 32'd5);
    check_val("bp_busy", 32'(busy), 32'd1);
    tx_fifo_full = 1'b0;
    wait_idle("bp", 400);
    expq = '{8'h5A, 8'h02, 8'h10, 8'h20, 8'h32};
    compare_tx("bp");
    check_val("bp_ok",    32'(oks - ok0), 32'd1);
    check_val("bp_pops2", 32'(pcq.size() - pop0), 32'd6);

    // asynchronous reset in the middle of a response
    stim = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
    load();
    n = 0;
    while (txq.size() - tx_base < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("ar_started", 32'(n < 200), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("ar_rd",   32'(rd_uart),   32'd0);
    check_val("ar_wr",   32'(wr_uart),   32'd0);
    check_val("ar_wdat", 32'(w_data),    32'd0);
    check_val("ar_ok",   32'(frame_ok),  32'd0);
    check_val("ar_err",  32'(frame_err), 32'd0);
    check_val("ar_busy", 32'(busy),      32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check_val("ar_residual", 32'(txq.size() - tx_base), 32'd2);
    tx_base = txq.size();

    check_val("tx_rule", 32'(tx_viol), 32'd0);
    check_val("rd_rule", 32'(rd_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
